// File: rtl/register_mode.sv
// register_mode: parametrised accumulator-style working register.
// Single-cycle load/clear/inc/dec, and multi-cycle 1-bit-per-clock
// shift/rotate sequences that use a start/busy/done handshake.
// Carry holds the last carry/borrow/shifted-out bit.
// Zero is a combinational decode of out.
module register_mode #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(8'b00010101),
  localparam int              AW          = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_CLEAR = 3'b010,
    OP_INC   = 3'b011,
    OP_DEC   = 3'b100,
    OP_SHL   = 3'b101,
    OP_SHR   = 3'b110,
    OP_ROTR  = 3'b111
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             carry_q, carry_d;
  logic             done_q,  done_d;
  logic [AW-1:0]    count_q, count_d;
  op_t              shop_q,  shop_d;

  // Next-state and datapath: accept a request in IDLE, or step a shift/rotate once per clock in SHIFT.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    count_d = count_q;
    shop_d  = shop_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_t'(op))
            OP_HOLD: begin
              done_d = 1'b1;
            end
            OP_LOAD: begin
              out_d   = data;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            OP_CLEAR: begin
              out_d   = '0;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            OP_INC: begin
              // The extra top bit of the sum is the wrap-around carry.
              {carry_d, out_d} = {1'b0, out_q} + (WIDTH+1)'(1);
              done_d = 1'b1;
            end
            OP_DEC: begin
              // The top bit becomes 1 only when 0 wraps to all-ones (borrow).
              {carry_d, out_d} = {1'b0, out_q} - (WIDTH+1)'(1);
              done_d = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ROTR: begin
              if (amount == '0) begin
                carry_d = 1'b0;
                done_d  = 1'b1;
              end else begin
                shop_d  = op_t'(op);
                count_d = amount;
                state_d = SHIFT;
              end
            end
          endcase
        end
      end

      SHIFT: begin
        case (shop_q)
          OP_SHL: begin
            carry_d = out_q[WIDTH-1];
            out_d   = {out_q[WIDTH-2:0], 1'b0};
          end
          OP_SHR: begin
            carry_d = out_q[0];
            out_d   = {1'b0, out_q[WIDTH-1:1]};
          end
          default: begin
            carry_d = out_q[0];
            out_d   = {out_q[0], out_q[WIDTH-1:1]};
          end
        endcase
        count_d = count_q - AW'(1);
        if (count_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register: asynchronous reset aborts any sequence and restores the reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= RESET_VALUE;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      shop_q  <= OP_SHL;
    end else begin
      // NOTE: non-blocking assignments make all flops update together from pre-edge values.
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      count_q <= count_d;
      shop_q  <= shop_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign done  = done_q;
  assign busy  = (state_q == SHIFT);
  assign zero  = (out_q == '0);

endmodule

// File: tb/tb_register_mode.sv
// Scoreboard bench for register_mode: an 8-bit default instance and a
// 16-bit instance with reset value 0x8000.
// Stimulus pushes the expected result of each accepted op into a queue.
// A monitor pops and compares the queue head whenever done is seen.
module tb_register_mode;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, CLR = 3'b010, INC = 3'b011,
                         DEC  = 3'b100, SHL  = 3'b101, SHR = 3'b110, ROTR = 3'b111;

  typedef struct {
    logic [15:0] out;
    logic        carry;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  data8   = '0;
  logic [2:0]  op8     = '0;
  logic        start8  = 1'b0;
  logic [2:0]  amount8 = '0;
  logic [7:0]  out8;
  logic        carry8, zero8, busy8, done8;

  logic [15:0] data16   = '0;
  logic [2:0]  op16     = '0;
  logic        start16  = 1'b0;
  logic [3:0]  amount16 = '0;
  logic [15:0] out16;
  logic        carry16, zero16, busy16, done16;

  register_mode dut8 (
    .clk(clk), .rst(rst), .data(data8), .op(op8), .start(start8), .amount(amount8),
    .out(out8), .carry(carry8), .zero(zero8), .busy(busy8), .done(done8)
  );

  register_mode #(.WIDTH(16), .RESET_VALUE(16'h8000)) dut16 (
    .clk(clk), .rst(rst), .data(data16), .op(op16), .start(start16), .amount(amount16),
    .out(out16), .carry(carry16), .zero(zero16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller is at a negedge; start is held for exactly one active edge.
  // Consecutive calls keep start high, giving back-to-back requests.
  task automatic issue8(input logic [2:0] op, input logic [7:0] d, input logic [2:0] amt,
                        input logic push, input logic [7:0] e_out, input logic e_carry);
    exp_t e;
    start8 = 1'b1; op8 = op; data8 = d; amount8 = amt;
    if (push) begin
      e.out = {8'h00, e_out}; e.carry = e_carry;
      sb8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] d, input logic [3:0] amt,
                         input logic [15:0] e_out, input logic e_carry);
    exp_t e;
    start16 = 1'b1; op16 = op; data16 = d; amount16 = amt;
    e.out = e_out; e.carry = e_carry;
    sb16.push_back(e);
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // Monitor for the 8-bit instance: compare against the queue head on every done pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done8 === 1'b1 && !rst) begin
      if (sb8.size() == 0) begin
        check("dut8 unexpected done", 32'(done8), 32'd0);
      end else begin
        e = sb8.pop_front();
        check("dut8 out",   32'(out8),   32'(e.out[7:0]));
        check("dut8 carry", 32'(carry8), 32'(e.carry));
        check("dut8 zero",  32'(zero8),  32'(e.out[7:0] == 8'h00));
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done16 === 1'b1 && !rst) begin
      if (sb16.size() == 0) begin
        check("dut16 unexpected done", 32'(done16), 32'd0);
      end else begin
        e = sb16.pop_front();
        check("dut16 out",   32'(out16),   32'(e.out));
        check("dut16 carry", 32'(carry16), 32'(e.carry));
        check("dut16 zero",  32'(zero16),  32'(e.out == 16'h0000));
      end
    end
  end

  // Watchdog: the sequence is short, so a long run means something hung.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;

    // Start in reset, release, then load a value so that the next reset is observable.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue8(LOAD, 8'h3C, 3'd0, 1'b1, 8'h3C, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #2 rst = 1'b1;
    #1;
    check("async rst out",   32'(out8),   32'h15);
    check("async rst carry", 32'(carry8), 32'd0);
    check("async rst zero",  32'(zero8),  32'd0);
    check("async rst busy",  32'(busy8),  32'd0);
    check("async rst done",  32'(done8),  32'd0);
    check("async rst out16", 32'(out16),  32'h8000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Load 0xFF, inc (wrap, carry), dec (borrow), back-to-back.
    issue8(LOAD, 8'hFF, 3'd0, 1'b1, 8'hFF, 1'b0);
    issue8(INC,  8'h00, 3'd0, 1'b1, 8'h00, 1'b1);
    issue8(DEC,  8'h00, 3'd0, 1'b1, 8'hFF, 1'b1);
    @(negedge clk);
    check("done is one cycle", 32'(done8), 32'd0);
    check("idle keeps out",    32'(out8),  32'hFF);

    // Hold keeps carry; clear zeroes both.
    issue8(HOLD, 8'h55, 3'd0, 1'b1, 8'hFF, 1'b1);
    issue8(CLR,  8'h55, 3'd0, 1'b1, 8'h00, 1'b0);

    // Load 0x81 then shl by 3: steps 0x02, 0x04, 0x08.
    issue8(LOAD, 8'h81, 3'd0, 1'b1, 8'h81, 1'b0);
    issue8(SHL,  8'h00, 3'd3, 1'b1, 8'h08, 1'b0);
    check("shl capture busy", 32'(busy8), 32'd1);
    check("shl capture out",  32'(out8),  32'h81);
    @(negedge clk);
    check("shl step1 busy",  32'(busy8),  32'd1);
    check("shl step1 out",   32'(out8),   32'h02);
    check("shl step1 carry", 32'(carry8), 32'd1);
    @(negedge clk);
    check("shl step2 busy", 32'(busy8), 32'd1);
    check("shl step2 out",  32'(out8),  32'h04);
    @(negedge clk);
    check("shl end busy", 32'(busy8), 32'd0);
    check("shl end done", 32'(done8), 32'd1);

    // Load 0x81, rotr by 1 gives 0xC0 with carry 1; then shr by 0 is a no-op.
    issue8(LOAD, 8'h81, 3'd0, 1'b1, 8'h81, 1'b0);
    issue8(ROTR, 8'h00, 3'd1, 1'b1, 8'hC0, 1'b1);
    check("rotr busy", 32'(busy8), 32'd1);
    @(negedge clk);
    check("rotr end busy", 32'(busy8), 32'd0);
    issue8(SHR, 8'h00, 3'd0, 1'b1, 8'hC0, 1'b0);
    check("shr0 busy never high", 32'(busy8), 32'd0);
    check("shr0 done next cycle", 32'(done8), 32'd1);

    // shl by 5 from 0x03 with an ignored load in the middle: 0x60, carry 0.
    issue8(LOAD, 8'h03, 3'd0, 1'b1, 8'h03, 1'b0);
    issue8(SHL,  8'h00, 3'd5, 1'b1, 8'h60, 1'b0);
    start8 = 1'b1; op8 = LOAD; data8 = 8'hAA; amount8 = 3'd0;
    @(negedge clk);
    start8 = 1'b0;
    check("busy start ignored", 32'(out8), 32'h06);
    repeat (4) @(negedge clk);
    check("shl5 final out", 32'(out8),  32'h60);
    check("shl5 final busy", 32'(busy8), 32'd0);

    // Another shl by 5, aborted by reset after step 2: no done pulse.
    @(negedge clk);
    issue8(SHL, 8'h00, 3'd5, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2;
    check("pre-abort out", 32'(out8), 32'h80);
    rst = 1'b1;
    #1;
    check("abort out",  32'(out8),  32'h15);
    check("abort busy", 32'(busy8), 32'd0);
    check("abort carry", 32'(carry8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("no done after abort", 32'(done8), 32'd0);

    // 16-bit instance: shr by 15 from 0x8000 gives 0x0001 after 15 busy cycles, then inc gives 0x0002.
    issue16(SHR, 16'h0000, 4'd15, 16'h0001, 1'b0);
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy16 === 1'b1; i++) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("dut16 busy cycles", 32'(busy_cycles), 32'd15);
    issue16(INC, 16'h0000, 4'd0, 16'h0002, 1'b0);

    repeat (3) @(negedge clk);
    check("dut8 scoreboard drained",  32'(sb8.size()),  32'd0);
    check("dut16 scoreboard drained", 32'(sb16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
